// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: bubble opcodes, FSM encoding and skid entry layout.
package instruction_fetch_pkg;

    localparam int unsigned PC_W   = 10;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned PAIR_W = 64;

    localparam logic [INSN_W-1:0] NOP_EVEN = 32'h4020_0000;
    localparam logic [INSN_W-1:0] LNOP_ODD = 32'h0020_0000;

    typedef enum logic [1:0] {
        RESET    = 2'b00,
        RUN      = 2'b01,
        REDIRECT = 2'b10
    } fetch_state_t;

    // One held pair: raw local-store data, its slot-1 PC and the odd-entry flag
    typedef struct packed {
        logic [PAIR_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic              odd;
        logic              valid;
    } skid_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction local-store read port: strobe and pair index out, pair data back one cycle later.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [PAIR_W-1:0] imem_rdata;

    modport master (output imem_rd_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_rd_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register that catches the pair returning while decode stalls.
module fetch_skid_buffer
    import instruction_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  skid_entry_t din,
    output skid_entry_t q
);

    // Clear (redirect) dominates; load and drain never coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear || drain) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Dual-issue fetch stage: one aligned pair per cycle, stall skid, branch redirect with bubbles.
// Optional FETCH_PERF_CNT_EN adds saturating pair and stall-cycle counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 10'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_W-1:0]      branch_target,
    instruction_fetch_if.master  imem,
    output logic [INSN_W-1:0]    instruction_out1,
    output logic [INSN_W-1:0]    instruction_out2,
    output logic [PC_W-1:0]      PC_out,
    output logic                 find_nop,
    output logic                 fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_pairs,
    output logic [31:0]          perf_stall_cycles
`endif
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inflight;
    logic            rd_pending;
    logic            odd_pending;
    logic            issue;
    logic            data_ok;
    logic            pair_load;
    logic            skid_load, skid_drain, skid_clear;
    skid_entry_t     skid_d, skid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Read issue and stale-data drop; REDIRECT never accepts returning data
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        data_ok   = 1'b0;
        unique case (state)
            RESET: begin
                issue     = rst && !stall && !branch_taken;
                state_nxt = branch_taken ? REDIRECT : RUN;
            end
            RUN: begin
                issue     = !stall && !branch_taken;
                data_ok   = rd_pending;
                state_nxt = branch_taken ? REDIRECT : RUN;
            end
            REDIRECT: begin
                issue     = !stall && !branch_taken;
                state_nxt = branch_taken ? REDIRECT : RUN;
            end
            default: state_nxt = RESET;
        endcase
    end

    assign imem.imem_rd_en = issue;
    assign imem.imem_addr  = issue ? pc[PC_W-1:1] : '0;

    // Returning data belongs to the pair issued last cycle, i.e. one pair behind pc
    assign pc_inflight = PC_W'(pc - PC_W'(2));
    assign skid_clear  = branch_taken;
    assign skid_drain  = !branch_taken && !stall && skid_q.valid;
    assign skid_load   = !branch_taken && stall && data_ok;
    assign pair_load   = !branch_taken && !stall && (skid_q.valid || data_ok);
    assign skid_d      = '{data: imem.imem_rdata, pc: pc_inflight, odd: odd_pending, valid: 1'b1};

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (skid_clear),
        .din   (skid_d),
        .q     (skid_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc               <= {RESET_PC[PC_W-1:1], 1'b0};
            rd_pending       <= 1'b0;
            odd_pending      <= 1'b0;
            instruction_out1 <= NOP_EVEN;
            instruction_out2 <= LNOP_ODD;
            PC_out           <= RESET_PC;
            find_nop         <= 1'b0;
            fetch_valid      <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (branch_taken) begin
                pc          <= {branch_target[PC_W-1:1], 1'b0};
                odd_pending <= branch_target[0];
            end else begin
                if (issue) pc <= PC_W'(pc + PC_W'(2));
                if (data_ok) odd_pending <= 1'b0;
            end

            if (pair_load) begin
                fetch_valid <= 1'b1;
                if (skid_q.valid) begin
                    instruction_out1 <= skid_q.data[PAIR_W-1 -: INSN_W];
                    instruction_out2 <= skid_q.data[INSN_W-1:0];
                    PC_out           <= skid_q.pc;
                    find_nop         <= skid_q.odd;
                end else begin
                    instruction_out1 <= imem.imem_rdata[PAIR_W-1 -: INSN_W];
                    instruction_out2 <= imem.imem_rdata[INSN_W-1:0];
                    PC_out           <= pc_inflight;
                    find_nop         <= odd_pending;
                end
            end else if (branch_taken || !stall) begin
                instruction_out1 <= NOP_EVEN;
                instruction_out2 <= LNOP_ODD;
                find_nop         <= 1'b0;
                fetch_valid      <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    localparam int unsigned PERF_W = 32;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_pairs        <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (pair_load && (perf_pairs != '1)) perf_pairs <= PERF_W'(perf_pairs + PERF_W'(1));
            if (stall && (perf_stall_cycles != '1)) perf_stall_cycles <= PERF_W'(perf_stall_cycles + PERF_W'(1));
        end
    end
`endif

endmodule
